// File: rtl/rf_bank_arbiter.sv
// rtl/rf_bank_arbiter.sv - banked register-file read arbiter with per-bank request FIFOs and CDB write priority
// Optional macro RF_ARB_STALL_CNT_EN enables the saturating write-blocked-read stall counter.
module rf_bank_arbiter #(
  parameter int NUM_BANKS  = 4,
  parameter int BANK_W     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int ROW_W      = 3,
  parameter int OCID_W     = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_two,
  input  logic [BANK_W-1:0]           req_bank_a,
  input  logic [BANK_W-1:0]           req_bank_b,
  input  logic [ROW_W-1:0]            req_row_a,
  input  logic [ROW_W-1:0]            req_row_b,
  input  logic [OCID_W-1:0]           req_ocid,
  input  logic                        wr_en,
  input  logic [BANK_W-1:0]           wr_bank,
  input  logic [ROW_W-1:0]            wr_row,
  output logic [NUM_BANKS-1:0]        rf_rd_valid,
  output logic [NUM_BANKS*ROW_W-1:0]  rf_rd_row,
  output logic [NUM_BANKS*OCID_W-1:0] rf_rd_ocid,
  output logic [NUM_BANKS-1:0]        rf_rd_slot,
  output logic [NUM_BANKS-1:0]        rf_wr_en,
  output logic [NUM_BANKS*ROW_W-1:0]  rf_wr_row,
  output logic [NUM_BANKS-1:0]        bank_busy,
  output logic [15:0]                 stall_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = OCID_W + 1 + ROW_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  // Entry layout {ocid, slot, row} matches the output register concatenation.
  logic [ENT_W-1:0] mem  [NUM_BANKS][FIFO_DEPTH];
  logic [PTR_W-1:0] rptr [NUM_BANKS];
  logic [PTR_W-1:0] wptr [NUM_BANKS];
  logic [CNT_W-1:0] cnt  [NUM_BANKS];
  logic [CNT_W-1:0] cnt_nxt [NUM_BANKS];

  logic                 same_bank;
  logic                 accept;
  logic [ENT_W-1:0]     ent_a;
  logic [ENT_W-1:0]     ent_b;
  logic [NUM_BANKS-1:0] enq_a;
  logic [NUM_BANKS-1:0] enq_b;
  logic [NUM_BANKS-1:0] wr_hit;
  logic [NUM_BANKS-1:0] pop;

  assign same_bank = (req_bank_a == req_bank_b);
  assign accept    = req_valid && req_ready;
  assign ent_a     = {req_ocid, 1'b0, req_row_a};
  assign ent_b     = {req_ocid, 1'b1, req_row_b};

  // Admission looks only at registered counts; a same-cycle pop earns no credit.
  always_comb begin
    req_ready = 1'b0;
    if (!req_two) begin
      req_ready = (cnt[req_bank_a] < DEPTH_C);
    end else if (same_bank) begin
      req_ready = (cnt[req_bank_a] <= DEPTH_C - CNT_W'(2));
    end else begin
      req_ready = (cnt[req_bank_a] < DEPTH_C) && (cnt[req_bank_b] < DEPTH_C);
    end
  end

  always_comb begin
    wr_hit    = '0;
    pop       = '0;
    enq_a     = '0;
    enq_b     = '0;
    bank_busy = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      cnt_nxt[b]   = cnt[b];
      wr_hit[b]    = wr_en && (wr_bank == BANK_W'(b));
      pop[b]       = (cnt[b] != '0) && !wr_hit[b];
      enq_a[b]     = accept && (req_bank_a == BANK_W'(b));
      enq_b[b]     = accept && req_two && (req_bank_b == BANK_W'(b));
      bank_busy[b] = (cnt[b] != '0);
      cnt_nxt[b]   = cnt[b] + CNT_W'(enq_a[b]) + CNT_W'(enq_b[b]) - CNT_W'(pop[b]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        rptr[b] <= '0;
        wptr[b] <= '0;
        cnt[b]  <= '0;
      end
      rf_rd_valid <= '0;
      rf_rd_row   <= '0;
      rf_rd_ocid  <= '0;
      rf_rd_slot  <= '0;
      rf_wr_en    <= '0;
      rf_wr_row   <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        // A same-bank pair puts A first so it drains ahead of B.
        if (enq_a[b]) begin
          mem[b][wptr[b]] <= ent_a;
        end
        if (enq_b[b]) begin
          mem[b][enq_a[b] ? wptr[b] + PTR_W'(1) : wptr[b]] <= ent_b;
        end
        wptr[b] <= wptr[b] + PTR_W'(enq_a[b]) + PTR_W'(enq_b[b]);
        if (pop[b]) begin
          rptr[b] <= rptr[b] + PTR_W'(1);
          {rf_rd_ocid[b*OCID_W +: OCID_W], rf_rd_slot[b], rf_rd_row[b*ROW_W +: ROW_W]} <= mem[b][rptr[b]];
        end
        cnt[b]                      <= cnt_nxt[b];
        rf_rd_valid[b]              <= pop[b];
        rf_wr_en[b]                 <= wr_hit[b];
        rf_wr_row[b*ROW_W +: ROW_W] <= wr_row;
      end
    end
  end

`ifdef RF_ARB_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (|(bank_busy & wr_hit) && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_rf_bank_arbiter.sv
// tb/tb_rf_bank_arbiter.sv - self-checking bench for rf_bank_arbiter with a queue-based reference model
module tb_rf_bank_arbiter;

  localparam int NB = 4;
  localparam int BW = 2;
  localparam int RW = 3;
  localparam int OW = 2;
  localparam int DEPTH = 4;
`ifdef RF_ARB_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req_valid = 1'b0;
  logic req_ready;
  logic req_two = 1'b0;
  logic [BW-1:0] req_bank_a = '0;
  logic [BW-1:0] req_bank_b = '0;
  logic [RW-1:0] req_row_a = '0;
  logic [RW-1:0] req_row_b = '0;
  logic [OW-1:0] req_ocid = '0;
  logic wr_en = 1'b0;
  logic [BW-1:0] wr_bank = '0;
  logic [RW-1:0] wr_row = '0;
  logic [NB-1:0] rf_rd_valid;
  logic [NB*RW-1:0] rf_rd_row;
  logic [NB*OW-1:0] rf_rd_ocid;
  logic [NB-1:0] rf_rd_slot;
  logic [NB-1:0] rf_wr_en;
  logic [NB*RW-1:0] rf_wr_row;
  logic [NB-1:0] bank_busy;
  logic [15:0] stall_cnt;

  rf_bank_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_two(req_two),
    .req_bank_a(req_bank_a), .req_bank_b(req_bank_b),
    .req_row_a(req_row_a), .req_row_b(req_row_b), .req_ocid(req_ocid),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_row(wr_row),
    .rf_rd_valid(rf_rd_valid), .rf_rd_row(rf_rd_row), .rf_rd_ocid(rf_rd_ocid),
    .rf_rd_slot(rf_rd_slot), .rf_wr_en(rf_wr_en), .rf_wr_row(rf_wr_row),
    .bank_busy(bank_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [RW-1:0] row;
    logic [OW-1:0] ocid;
    logic          slot;
  } ent_t;

  ent_t          q[NB][$];
  logic [NB-1:0] m_rd_valid;
  logic [NB-1:0] m_wr_en;
  ent_t          m_ent[NB];
  logic [RW-1:0] m_wr_row;
  int            m_stall;
  int            tests_run = 0;
  int            tests_failed = 0;

  function automatic bit model_ready();
    int fa;
    int fb;
    fa = DEPTH - q[req_bank_a].size();
    fb = DEPTH - q[req_bank_b].size();
    if (!req_two) return fa >= 1;
    if (req_bank_a == req_bank_b) return fa >= 2;
    return (fa >= 1) && (fb >= 1);
  endfunction

  function automatic logic [NB-1:0] model_busy();
    logic [NB-1:0] v;
    for (int b = 0; b < NB; b++) v[b] = (q[b].size() != 0);
    return v;
  endfunction

  // Advances the model by one edge from the currently driven inputs, then clocks the DUT.
  task automatic tick();
    bit   acc;
    bit   blk;
    bit   any_stall;
    ent_t e;
    acc = req_valid && model_ready();
    if (!rst) begin
      for (int b = 0; b < NB; b++) begin
        q[b].delete();
        m_ent[b] = '0;
      end
      m_rd_valid = '0;
      m_wr_en    = '0;
      m_wr_row   = '0;
      m_stall    = 0;
    end else begin
      any_stall = 1'b0;
      for (int b = 0; b < NB; b++) begin
        blk = wr_en && (int'(wr_bank) == b);
        m_wr_en[b] = blk;
        if (q[b].size() != 0 && blk) any_stall = 1'b1;
        if (q[b].size() != 0 && !blk) begin
          m_ent[b] = q[b].pop_front();
          m_rd_valid[b] = 1'b1;
        end else begin
          m_rd_valid[b] = 1'b0;
        end
      end
      m_wr_row = wr_row;
      if (STALL_EN && any_stall && m_stall < 65535) m_stall++;
      if (acc) begin
        e.row = req_row_a; e.ocid = req_ocid; e.slot = 1'b0;
        q[req_bank_a].push_back(e);
        if (req_two) begin
          e.row = req_row_b; e.slot = 1'b1;
          q[req_bank_b].push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0;
    req_two   = 1'b0;
    wr_en     = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    tick();
    tests_run++;
    if (rf_rd_valid !== 4'b0 || rf_wr_en !== 4'b0 || rf_rd_row !== '0 || rf_wr_row !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs rd_valid=%b wr_en=%b rd_row=%h wr_row=%h required all 0", rf_rd_valid, rf_wr_en, rf_rd_row, rf_wr_row);
    end
    tests_run++;
    if (bank_busy !== 4'b0 || stall_cnt !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_busy_stall busy=%b stall=%0d required 0/0", bank_busy, stall_cnt);
    end
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready got=%b required=1", req_ready);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    req_valid = 1'b1; req_two = 1'b0; req_bank_a = 2'd2; req_row_a = 3'd5; req_ocid = 2'd1;
    #1;
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_ready got=%b required=1", req_ready);
    end
    tick();
    req_valid = 1'b0;
    tests_run++;
    if (rf_rd_valid !== 4'b0000 || bank_busy !== 4'b0100) begin
      tests_failed++;
      $display("FAIL single_edge0 rd_valid=%b busy=%b required 0000/0100", rf_rd_valid, bank_busy);
    end
    tick();
    tests_run++;
    if (rf_rd_valid !== 4'b0100 || rf_rd_row[2*RW +: RW] !== 3'd5 || rf_rd_ocid[2*OW +: OW] !== 2'd1 || rf_rd_slot[2] !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_read rd_valid=%b row=%0d ocid=%0d slot=%b required 0100/5/1/0",
               rf_rd_valid, rf_rd_row[2*RW +: RW], rf_rd_ocid[2*OW +: OW], rf_rd_slot[2]);
    end
    tick();
    tests_run++;
    if (rf_rd_valid !== 4'b0000) begin
      tests_failed++;
      $display("FAIL single_one_cycle rd_valid=%b required=0000", rf_rd_valid);
    end
  endtask

  task automatic test_same_bank_pair();
    req_valid = 1'b1; req_two = 1'b1; req_bank_a = 2'd1; req_bank_b = 2'd1;
    req_row_a = 3'd3; req_row_b = 3'd6; req_ocid = 2'd2;
    tick();
    idle_inputs();
    tick();
    tests_run++;
    if (rf_rd_valid !== 4'b0010 || rf_rd_row[RW +: RW] !== 3'd3 || rf_rd_slot[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL pair_first rd_valid=%b row=%0d slot=%b required 0010/3/0", rf_rd_valid, rf_rd_row[RW +: RW], rf_rd_slot[1]);
    end
    tick();
    tests_run++;
    if (rf_rd_valid !== 4'b0010 || rf_rd_row[RW +: RW] !== 3'd6 || rf_rd_slot[1] !== 1'b1 || rf_rd_ocid[OW +: OW] !== 2'd2) begin
      tests_failed++;
      $display("FAIL pair_second rd_valid=%b row=%0d slot=%b ocid=%0d required 0010/6/1/2",
               rf_rd_valid, rf_rd_row[RW +: RW], rf_rd_slot[1], rf_rd_ocid[OW +: OW]);
    end
    tick();
  endtask

  task automatic test_fifo_full();
    wr_en = 1'b1; wr_bank = 2'd0; wr_row = 3'd1;
    req_valid = 1'b1; req_two = 1'b0; req_bank_a = 2'd0;
    for (int i = 0; i < DEPTH; i++) begin
      req_row_a = RW'(i);
      #1;
      tests_run++;
      if (req_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL full_fill_ready entry=%0d got=%b required=1", i, req_ready);
      end
      tick();
    end
    tests_run++;
    if (req_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_bank0_ready got=%b required=0", req_ready);
    end
    tick();
    req_bank_a = 2'd3;
    #1;
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_bank3_ready got=%b required=1", req_ready);
    end
    tick();
    tests_run++;
    if (bank_busy !== 4'b1001) begin
      tests_failed++;
      $display("FAIL full_busy got=%b required=1001", bank_busy);
    end
    req_valid = 1'b0; wr_en = 1'b0;
    tick();
    tests_run++;
    if (rf_rd_valid !== 4'b1001 || rf_rd_row[0 +: RW] !== 3'd0) begin
      tests_failed++;
      $display("FAIL full_first_pop rd_valid=%b row0=%0d required 1001/0", rf_rd_valid, rf_rd_row[0 +: RW]);
    end
    wr_en = 1'b1; req_valid = 1'b1; req_two = 1'b1; req_bank_a = 2'd0; req_bank_b = 2'd0;
    #1;
    tests_run++;
    if (req_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_pair_at3 got=%b required=0", req_ready);
    end
    req_bank_b = 2'd2;
    #1;
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_split_pair_at3 got=%b required=1", req_ready);
    end
    idle_inputs();
    repeat (6) tick();
  endtask

  task automatic test_write_priority();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    req_valid = 1'b1; req_two = 1'b0; req_bank_a = 2'd3; req_row_a = 3'd2; req_ocid = 2'd3;
    tick();
    req_valid = 1'b0; wr_en = 1'b1; wr_bank = 2'd3; wr_row = 3'd4;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (rf_wr_en !== 4'b1000 || rf_rd_valid !== 4'b0000 || rf_wr_row[3*RW +: RW] !== 3'd4) begin
        tests_failed++;
        $display("FAIL wpri_blocked cyc=%0d wr_en=%b rd_valid=%b wr_row=%0d required 1000/0000/4",
                 i, rf_wr_en, rf_rd_valid, rf_wr_row[3*RW +: RW]);
      end
    end
    wr_en = 1'b0;
    tick();
    tests_run++;
    if (rf_rd_valid !== 4'b1000 || rf_wr_en !== 4'b0000 || rf_rd_row[3*RW +: RW] !== 3'd2) begin
      tests_failed++;
      $display("FAIL wpri_release rd_valid=%b wr_en=%b row=%0d required 1000/0000/2", rf_rd_valid, rf_wr_en, rf_rd_row[3*RW +: RW]);
    end
    tests_run++;
    if (stall_cnt !== (STALL_EN ? 16'd3 : 16'd0)) begin
      tests_failed++;
      $display("FAIL wpri_stall got=%0d required=%0d", stall_cnt, STALL_EN ? 3 : 0);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    wr_en = 1'b1; wr_bank = 2'd0; wr_row = 3'd7;
    req_valid = 1'b1; req_two = 1'b1; req_ocid = 2'd0;
    req_bank_a = 2'd0; req_bank_b = 2'd0; req_row_a = 3'd1; req_row_b = 3'd2;
    tick();
    req_bank_a = 2'd1; req_bank_b = 2'd1; req_row_a = 3'd3; req_row_b = 3'd4;
    tick();
    req_bank_a = 2'd2; req_bank_b = 2'd3; req_row_a = 3'd5; req_row_b = 3'd6;
    tick();
    tests_run++;
    if (bank_busy !== 4'b1111) begin
      tests_failed++;
      $display("FAIL rmid_busy_before got=%b required=1111", bank_busy);
    end
    rst = 1'b0;
    req_bank_a = 2'd2; req_bank_b = 2'd2;
    tick();
    tests_run++;
    if (rf_rd_valid !== '0 || rf_rd_row !== '0 || rf_rd_ocid !== '0 || rf_rd_slot !== '0 ||
        rf_wr_en !== '0 || rf_wr_row !== '0 || bank_busy !== '0 || stall_cnt !== '0) begin
      tests_failed++;
      $display("FAIL rmid_outputs rd_valid=%b row=%h ocid=%h slot=%b wr_en=%b wr_row=%h busy=%b stall=%0d required all 0",
               rf_rd_valid, rf_rd_row, rf_rd_ocid, rf_rd_slot, rf_wr_en, rf_wr_row, bank_busy, stall_cnt);
    end
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rmid_ready got=%b required=1", req_ready);
    end
    rst = 1'b1;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (rf_rd_valid !== 4'b0000 || bank_busy !== 4'b0000) begin
        tests_failed++;
        $display("FAIL rmid_stale cyc=%0d rd_valid=%b busy=%b required 0000/0000", i, rf_rd_valid, bank_busy);
      end
    end
  endtask

  task automatic test_random();
    logic [NB-1:0] exp_busy;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst        = ($urandom_range(0, 149) != 0);
      req_valid  = ($urandom_range(0, 9) < 7);
      req_two    = $urandom_range(0, 1) != 0;
      req_bank_a = BW'($urandom_range(0, NB - 1));
      req_bank_b = ($urandom_range(0, 3) == 0) ? req_bank_a : BW'($urandom_range(0, NB - 1));
      req_row_a  = RW'($urandom);
      req_row_b  = RW'($urandom);
      req_ocid   = OW'($urandom);
      wr_en      = ($urandom_range(0, 3) == 0);
      wr_bank    = BW'($urandom_range(0, NB - 1));
      wr_row     = RW'($urandom);
      #1;
      tests_run++;
      if (req_ready !== model_ready()) begin
        tests_failed++;
        $display("FAIL rand_ready cyc=%0d got=%b required=%b", cyc, req_ready, model_ready());
      end
      tick();
      tests_run++;
      if (rf_rd_valid !== m_rd_valid) begin
        tests_failed++;
        $display("FAIL rand_rd_valid cyc=%0d got=%b required=%b", cyc, rf_rd_valid, m_rd_valid);
      end
      for (int b = 0; b < NB; b++) begin
        if (m_rd_valid[b]) begin
          tests_run++;
          if ({rf_rd_row[b*RW +: RW], rf_rd_ocid[b*OW +: OW], rf_rd_slot[b]} !== m_ent[b]) begin
            tests_failed++;
            $display("FAIL rand_entry cyc=%0d bank=%0d got=%h required=%h", cyc, b,
                     {rf_rd_row[b*RW +: RW], rf_rd_ocid[b*OW +: OW], rf_rd_slot[b]}, m_ent[b]);
          end
        end
      end
      tests_run++;
      if (rf_wr_en !== m_wr_en || rf_wr_row !== {NB{m_wr_row}}) begin
        tests_failed++;
        $display("FAIL rand_write cyc=%0d wr_en=%b wr_row=%h required %b/%h", cyc, rf_wr_en, rf_wr_row, m_wr_en, {NB{m_wr_row}});
      end
      exp_busy = model_busy();
      tests_run++;
      if (bank_busy !== exp_busy || stall_cnt !== 16'(m_stall)) begin
        tests_failed++;
        $display("FAIL rand_busy_stall cyc=%0d busy=%b stall=%0d required %b/%0d", cyc, bank_busy, stall_cnt, exp_busy, m_stall);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    m_rd_valid = '0;
    m_wr_en    = '0;
    m_wr_row   = '0;
    m_stall    = 0;
    for (int b = 0; b < NB; b++) m_ent[b] = '0;
    test_reset();
    test_single();
    test_same_bank_pair();
    test_fifo_full();
    test_write_priority();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rf_bank_arbiter.md
RF_BANK_ARBITER -- requirements
Module: rf_bank_arbiter

Interface
REQ-001 Parameter NUM_BANKS, 4: number of register-file banks; SHALL be a power of 2.
REQ-002 Parameter BANK_W, 2: bank-select width; SHALL equal log2(NUM_BANKS).
REQ-003 Parameter FIFO_DEPTH, 4: per-bank request FIFO entries; SHALL be a power of 2 and at least 2.
REQ-004 Parameter ROW_W, 3: register row address width.
REQ-005 Parameter OCID_W, 2: operand-collector ID width.
REQ-006 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-007 rst  in  1  synchronous, active-low reset.
REQ-008 req_valid  in  1  operand-read request present.
REQ-009 req_ready  out  1  request accepted on this edge when req_valid is also high.
REQ-010 req_two  in  1  1 = operands A and B; 0 = operand A only, B fields ignored.
REQ-011 req_bank_a, req_bank_b  in  BANK_W  target bank of operand A / B.
REQ-012 req_row_a, req_row_b  in  ROW_W  row within the bank for operand A / B.
REQ-013 req_ocid  in  OCID_W  requesting collector ID.
REQ-014 wr_en  in  1  CDB register write request.
REQ-015 wr_bank  in  BANK_W; wr_row  in  ROW_W  CDB write target.
REQ-016 rf_rd_valid  out  NUM_BANKS  per-bank read strobe.
REQ-017 rf_rd_row  out  NUM_BANKS*ROW_W; rf_rd_ocid  out  NUM_BANKS*OCID_W; rf_rd_slot  out  NUM_BANKS (0=A, 1=B)  packed per bank, bank 0 in the LSBs.
REQ-018 rf_wr_en  out  NUM_BANKS; rf_wr_row  out  NUM_BANKS*ROW_W  per-bank write strobe and row.
REQ-019 bank_busy  out  NUM_BANKS  bank FIFO non-empty.
REQ-020 stall_cnt  out  16  write-blocked-read counter (see Configuration).

Function
REQ-021 Each bank SHALL own a FIFO of FIFO_DEPTH entries {ocid, slot, row}, with a read pointer, a write pointer and an occupancy count; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-022 req_ready SHALL be combinational from the registered occupancy counts only, with no credit for same-cycle pops:
- req_two=0: high iff FIFO[bank_a] has at least 1 free entry.
- req_two=1, different banks: high iff each target FIFO has at least 1 free entry.
- req_two=1, same bank: high iff that FIFO has at least 2 free entries.
REQ-023 On accept, A SHALL be enqueued with slot=0 and B with slot=1. For a same-bank pair, A SHALL occupy the lower FIFO position, so A is popped before B.
REQ-024 No partial acceptance: both operands are enqueued or neither is.
REQ-025 Bank b SHALL pop its head at an edge iff its FIFO is non-empty and NOT (wr_en && wr_bank==b). Writes always take priority over reads.
REQ-026 A pop SHALL load rf_rd_valid[b], row, ocid and slot into the output registers. The entry is therefore presented in the cycle after the pop edge: two edges after accept, minimum.
REQ-027 At each edge rf_wr_en[b] SHALL register (wr_en && wr_bank==b), and rf_wr_row[b] SHALL register wr_row. Write latency is 1 cycle.
REQ-028 rf_rd_valid[b] and rf_wr_en[b] SHALL never be high in the same cycle.
REQ-029 A simultaneous enqueue and pop on one bank SHALL leave the count unchanged for a single-entry enqueue, and increase it by 1 for a same-bank pair.
REQ-030 A full FIFO SHALL never be overwritten. Pop SHALL never occur on an empty FIFO.
REQ-031 bank_busy[b] SHALL equal (count[b] != 0) from registered state.

Reset
REQ-032 When rst=0 at an edge, the block SHALL:
- clear all counts and pointers;
- clear rf_rd_valid, rf_rd_row, rf_rd_ocid, rf_rd_slot, rf_wr_en, rf_wr_row and stall_cnt to 0.
REQ-033 Reset asserted mid-operation SHALL discard all queued entries. req_ready SHALL read 1 during reset (all FIFOs empty), but no request is accepted on a reset edge.

Configuration
REQ-034 Macro RF_ARB_STALL_CNT_EN, when defined:
- stall_cnt SHALL increment by 1 on each edge where at least one bank is non-empty and write-blocked;
- it SHALL saturate at 16'hFFFF;
- only reset clears it.
REQ-035 When RF_ARB_STALL_CNT_EN is undefined, stall_cnt SHALL be constant 0 and no counter logic SHALL be synthesised.

Verification
REQ-036 Single request A: bank 2, row 5, ocid 1 accepted at edge 0 -> after edge 1, rf_rd_valid=4'b0100, row 5, ocid 1, slot 0; high for 1 cycle.
REQ-037 Same-bank pair A: bank 1 row 3, B: bank 1 row 6 -> bank 1 presents row 3 slot 0, then row 6 slot 1, on consecutive cycles.
REQ-038 FIFO full, defaults: 4 single requests to bank 0 with no pops (held by wr_en on bank 0) -> req_ready=0 for a bank-0 request while a bank-3 request is accepted; same-bank pairs are refused at 3 entries.
REQ-039 Write priority: bank 3 non-empty with wr_en=1, wr_bank=3 for 3 cycles -> rf_wr_en[3] high for 3 cycles, no bank-3 read in those cycles, the read appears the cycle after; with the macro, stall_cnt=3.
REQ-040 Reset with entries queued in all banks -> next cycle all outputs 0, bank_busy=0, and no stale read appears after release.
